pipe_seq: RTL and testbench

Sequencer for the pipelined fixed-point multiply-accumulate datapath (`pipe`). It buffers an operand vector pair (A[i], B[i], 16-bit 8.8 fixed point), then drives the pipe's `wrAddr` command port: one clear, one accumulate per element with a configurable idle gap, and a drain. It captures `result` once the pipeline has flushed and reports completion. It sits between the host/load interface and a single `pipe` instance, replacing hand-sequenced testbench stimulus.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/vec_buf.sv | 30 +++
 rtl/pipe_seq.sv | 168 ++++++++++++++++
 tb/tb_pipe_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg : command codes, sequencer states and widths for pipe_seq
// Revision: 1.0
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int DATA_W_DEF = 16;

  localparam logic [3:0] CMD_IDLE = 4'd0;
  localparam logic [3:0] CMD_ACC  = 4'd1;
  localparam logic [3:0] CMD_CLR  = 4'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ISSUE = 3'd2,
    S_GAP   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/vec_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vec_buf : operand-pair storage, one synchronous write, one async read port
// Revision: 1.0
// ---------------------------------------------------------------------------
module vec_buf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/pipe_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_seq : buffers A/B operand pairs and sequences clear/acc/drain on pipe
// Revision: 1.0
// ---------------------------------------------------------------------------
module pipe_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  parameter int GAP    = 0,
  parameter int DRAIN  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_valid,
  input  logic [DATA_W-1:0]          load_a,
  input  logic [DATA_W-1:0]          load_b,
  output logic                       load_ready,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     len,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [DATA_W-1:0]          result,
  output logic [DATA_W-1:0]          pipe_a,
  output logic [DATA_W-1:0]          pipe_b,
  output logic [3:0]                 pipe_cmd,
  input  logic [DATA_W-1:0]          pipe_result
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int TMAX = (GAP > DRAIN) ? GAP : DRAIN;
  localparam int TW   = $clog2(TMAX + 1);
  localparam bit HAS_GAP = (GAP > 0);
  localparam logic [TW-1:0] GAP_LAST   = TW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN - 1);

  state_t               state_q, state_d;
  logic [LW-1:0]        count_q, count_d;
  logic [LW-1:0]        len_q, len_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 err_q, err_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic                 wr_en;
  logic [2*DATA_W-1:0]  rd_data;

  assign load_ready = (state_q == S_IDLE) && !start && (count_q < LW'(DEPTH));
  assign wr_en      = load_valid && load_ready;

  vec_buf #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DATA_W)
  ) u_vec_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (count_q[AW-1:0]),
    .wdata ({load_a, load_b}),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      len_q    <= '0;
      rd_ptr_q <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      len_q    <= len_d;
      rd_ptr_q <= rd_ptr_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    len_d    = len_q;
    rd_ptr_d = rd_ptr_q;
    timer_d  = timer_q;
    err_d    = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        // start wins over a same-cycle load; load_ready already excludes it
        if (start) begin
          if (len <= count_q) begin
            state_d = S_CLEAR;
            len_d   = len;
          end else begin
            err_d = 1'b1;
          end
        end else if (wr_en) begin
          count_d = count_q + LW'(1);
        end
      end
      S_CLEAR: begin
        rd_ptr_d = '0;
        timer_d  = '0;
        state_d  = (len_q == '0) ? S_DRAIN : S_ISSUE;
      end
      S_ISSUE: begin
        timer_d = '0;
        if ({1'b0, rd_ptr_q} == len_q - LW'(1)) begin
          state_d = S_DRAIN;
        end else begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          if (HAS_GAP) begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          state_d = S_ISSUE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DRAIN: begin
        // pipe_result is sampled on the edge closing the final drain cycle
        if (timer_q == DRAIN_LAST) begin
          state_d  = S_DONE;
          result_d = pipe_result;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE: begin
        count_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pipe_cmd = CMD_IDLE;
    pipe_a   = '0;
    pipe_b   = '0;
    case (state_q)
      S_CLEAR: pipe_cmd = CMD_CLR;
      S_ISSUE: begin
        pipe_cmd = CMD_ACC;
        pipe_a   = rd_data[2*DATA_W-1:DATA_W];
        pipe_b   = rd_data[DATA_W-1:0];
      end
      default: pipe_cmd = CMD_IDLE;
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign err    = err_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_seq : drives a GAP=0 and a GAP=62 sequencer with identical stimulus
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pipe_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [15:0] load_a, load_b;
  logic        start;
  logic [4:0]  len;

  logic [1:0]  ready_w, busy_w, done_w, err_w;
  logic [15:0] res_w [2];
  logic [15:0] pa_w [2];
  logic [15:0] pb_w [2];
  logic [3:0]  cmd_w [2];
  logic [15:0] pres_w [2];

  int checks = 0;
  int failures = 0;

  logic [15:0] ma [16];
  logic [15:0] mb [16];
  int          mcount = 0;

  logic [15:0] DA [17];
  logic [15:0] DB [17];

  always #5 clk = ~clk;

  pipe_seq #(.DATA_W(16), .DEPTH(16), .GAP(0), .DRAIN(4)) u_dut0 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_a(load_a), .load_b(load_b),
    .load_ready(ready_w[0]), .start(start), .len(len), .busy(busy_w[0]), .done(done_w[0]),
    .err(err_w[0]), .result(res_w[0]), .pipe_a(pa_w[0]), .pipe_b(pb_w[0]),
    .pipe_cmd(cmd_w[0]), .pipe_result(pres_w[0])
  );

  pipe_seq #(.DATA_W(16), .DEPTH(16), .GAP(62), .DRAIN(4)) u_dut1 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_a(load_a), .load_b(load_b),
    .load_ready(ready_w[1]), .start(start), .len(len), .busy(busy_w[1]), .done(done_w[1]),
    .err(err_w[1]), .result(res_w[1]), .pipe_a(pa_w[1]), .pipe_b(pb_w[1]),
    .pipe_cmd(cmd_w[1]), .pipe_result(pres_w[1])
  );

  function automatic logic [15:0] fx_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[23:8];
  endfunction

  // Behavioural pipe: accumulator followed by two stages of output latency
  for (genvar k = 0; k < 2; k++) begin : g_pipe
    logic [15:0] acc, d1, d2;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc <= '0; d1 <= '0; d2 <= '0;
      end else begin
        if (cmd_w[k] == 4'd2) acc <= '0;
        else if (cmd_w[k] == 4'd1) acc <= acc + fx_mul(pa_w[k], pb_w[k]);
        d1 <= acc;
        d2 <= d1;
      end
    end
    assign pres_w[k] = d2;
  end

  function automatic logic [15:0] dot(input int n);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = s + fx_mul(ma[i], mb[i]);
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load_one(input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    load_valid = 1'b1; load_a = a; load_b = b;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk($sformatf("load_ready%0d", k), 64'(ready_w[k]), 64'(mcount < 16));
    if (mcount < 16) begin
      ma[mcount] = a; mb[mcount] = b; mcount++;
    end
  endtask

  task automatic do_start(input int L, input bit exp_err, input int d0, input int d1,
                          input logic [15:0] exp_res);
    int dexp [2];
    int bad [2];
    int bad_c [2];
    int fd [2];
    logic [38:0] bad_a [2];
    logic [38:0] bad_e [2];
    int last;
    dexp[0] = d0; dexp[1] = d1;
    @(posedge clk); #1;
    load_valid = 1'b0; start = 1'b1; len = 5'(L);
    @(posedge clk); #1;
    start = 1'b0;
    if (exp_err) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("err_pulse%0d", k), 64'(err_w[k]), 64'd1);
        chk($sformatf("err_busy%0d", k), 64'(busy_w[k]), 64'd0);
        chk($sformatf("err_cmd%0d", k), 64'(cmd_w[k]), 64'd0);
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("err_clear%0d", k), 64'(err_w[k]), 64'd0);
        chk($sformatf("err_busy2_%0d", k), 64'(busy_w[k]), 64'd0);
      end
      return;
    end
    last = ((d0 > d1) ? d0 : d1) + 1;
    for (int k = 0; k < 2; k++) begin
      bad[k] = 0; bad_c[k] = 0; fd[k] = -1; bad_a[k] = '0; bad_e[k] = '0;
    end
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        int g;
        int i;
        logic [3:0]  ecmd;
        logic [15:0] ea, eb;
        logic [38:0] av, ev;
        g = (k == 0) ? 0 : 62;
        ecmd = 4'd0; ea = '0; eb = '0;
        if (c == 1) begin
          ecmd = 4'd2;
        end else if (L > 0 && c < 2 + L * (1 + g) && ((c - 2) % (1 + g)) == 0) begin
          i = (c - 2) / (1 + g);
          ecmd = 4'd1; ea = ma[i]; eb = mb[i];
        end
        ev = {ecmd, ea, eb, 1'(c == dexp[k]), 1'(c <= dexp[k]), 1'b0};
        av = {cmd_w[k], pa_w[k], pb_w[k], done_w[k], busy_w[k], err_w[k]};
        if (av !== ev) begin
          if (bad[k] == 0) begin
            bad_c[k] = c; bad_a[k] = av; bad_e[k] = ev;
          end
          bad[k]++;
        end
        if (done_w[k] && fd[k] < 0) fd[k] = c;
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bad[k] != 0) begin
        failures++;
        $display("FAIL trace%0d cycle=%0d actual=%h required=%h badcycles=%0d",
                 k, bad_c[k], bad_a[k], bad_e[k], bad[k]);
      end
      chk($sformatf("done_cycle%0d", k), 64'(fd[k]), 64'(dexp[k]));
      chk($sformatf("result%0d", k), 64'(res_w[k]), 64'(exp_res));
    end
    mcount = 0;
  endtask

  typedef struct {
    int          n_load;
    int          len;
    bit          exp_err;
    int          done0;
    int          done62;
    bit          lit_res;
    logic [15:0] res;
  } vec_t;

  vec_t tbl [6];

  initial begin
    DA = '{16'h0140, 16'h0280, 16'h0280, 16'h0200, 16'h0300, 16'h0200, 16'h0140, 16'h0380,
           16'h0480, 16'h0200, 16'hFF00, 16'h0110, 16'h7F00, 16'h8000, 16'h0001, 16'h00FF,
           16'hDEAD};
    DB = '{16'h0180, 16'h0180, 16'h0500, 16'h0200, 16'h0500, 16'h0300, 16'h0380, 16'h0500,
           16'h0400, 16'h0300, 16'h0240, 16'hFE80, 16'h0100, 16'h0002, 16'h0300, 16'h0101,
           16'hBEEF};
    tbl[0] = '{10, 10, 1'b0, 16, 574, 1'b1, 16'h5900};
    tbl[1] = '{10, 11, 1'b1, 0, 0, 1'b0, 16'h0000};
    tbl[2] = '{0, 10, 1'b0, 16, 574, 1'b1, 16'h5900};
    tbl[3] = '{17, 16, 1'b0, 22, 952, 1'b0, 16'h0000};
    tbl[4] = '{3, 0, 1'b0, 6, 6, 1'b1, 16'h0000};
    tbl[5] = '{4, 1, 1'b0, 7, 7, 1'b0, 16'h0000};

    reset = 1'b1; load_valid = 1'b0; load_a = '0; load_b = '0; start = 1'b0; len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_cmd%0d", k), 64'(cmd_w[k]), 64'd0);
      chk($sformatf("rst_ab%0d", k), 64'({pa_w[k], pb_w[k]}), 64'd0);
      chk($sformatf("rst_flags%0d", k), 64'({busy_w[k], done_w[k], err_w[k]}), 64'd0);
      chk($sformatf("rst_result%0d", k), 64'(res_w[k]), 64'd0);
      chk($sformatf("rst_ready%0d", k), 64'(ready_w[k]), 64'd1);
    end
    @(posedge clk); #1; reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk($sformatf("idle_cmd%0d", k), 64'({cmd_w[k], busy_w[k]}), 64'd0);
    end

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < tbl[t].n_load; i++) load_one(DA[i], DB[i]);
      do_start(tbl[t].len, tbl[t].exp_err, tbl[t].done0, tbl[t].done62,
               tbl[t].lit_res ? tbl[t].res : dot(tbl[t].len));
    end

    // reset asserted mid-run, while element 5 is being issued
    for (int i = 0; i < 10; i++) load_one(DA[i], DB[i]);
    @(posedge clk); #1; load_valid = 1'b0; start = 1'b1; len = 5'd10;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(negedge clk);
    chk("issue5_cmd", 64'(cmd_w[0]), 64'd1);
    chk("issue5_a", 64'(pa_w[0]), 64'(DA[5]));
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("arst_cmd%0d", k), 64'(cmd_w[k]), 64'd0);
      chk($sformatf("arst_busy%0d", k), 64'(busy_w[k]), 64'd0);
      chk($sformatf("arst_result%0d", k), 64'(res_w[k]), 64'd0);
      chk($sformatf("arst_ready%0d", k), 64'(ready_w[k]), 64'd1);
    end
    @(posedge clk); #1; reset = 1'b0;
    mcount = 0;
    for (int i = 0; i < 3; i++) load_one(16'($urandom), 16'($urandom));
    do_start(3, 1'b0, 9, 133, dot(3));

    repeat (5) begin
      int n;
      int L;
      n = $urandom_range(16, 1);
      for (int i = 0; i < n; i++) load_one(16'($urandom), 16'($urandom));
      L = $urandom_range((n < 16) ? n + 1 : 16, 0);
      if (L > n) begin
        do_start(L, 1'b1, 0, 0, 16'h0);
        L = $urandom_range(n, 0);
      end
      do_start(L, 1'b0, (L == 0) ? 6 : 3 + (L - 1) + 4,
               (L == 0) ? 6 : 3 + (L - 1) * 63 + 4, dot(L));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
